// File: rtl/dp_ring_buffer.sv
// rtl/dp_ring_buffer.sv - two-port circular buffer with registered read, occupancy count and sticky drop flags
module dp_ring_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        weA,
    input  logic [DATA_W-1:0]           dataInA,
    input  logic                        weB,
    output logic [DATA_W-1:0]           outB,
    output logic                        validB,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_accept;
    logic              wr_accept;

    // Status flags decode the registered occupancy directly.
    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_C);

    // A read frees a slot in the same cycle, so a full buffer can still take a write alongside a read.
    assign rd_accept = weB & ~empty;
    assign wr_accept = weA & (~full | rd_accept);

    // Storage array: not reset; when full with a concurrent read, the write lands in the slot being read out.
    always_ff @(posedge clk) begin
        if (!clear && wr_accept) begin
            mem[wr_ptr] <= dataInA;
        end
    end

    // Pointers, occupancy, registered read port and sticky drop flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            outB      <= '0;
            validB    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            validB    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                outB   <= mem[rd_ptr];
            end
            validB <= rd_accept;
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (weA && full && !rd_accept) begin
                overflow <= 1'b1;
            end
            if (weB && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dp_ring_buffer.sv
// tb/tb_dp_ring_buffer.sv - scoreboard bench for dp_ring_buffer
module tb_dp_ring_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              weA;
    logic [DATA_W-1:0] dataInA;
    logic              weB;
    logic [DATA_W-1:0] outB;
    logic              validB;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] model [$];
    logic [DATA_W-1:0] exp_q [$];
    logic              m_ovf;
    logic              m_unf;
    logic              m_valid;
    logic [DATA_W-1:0] m_out;
    logic              af_seen;

    dp_ring_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .weA(weA), .dataInA(dataInA), .weB(weB),
        .outB(outB), .validB(validB), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        chk("count", 32'(count), 32'(model.size()));
        chk("full", 32'(full), 32'(model.size() == DEPTH));
        chk("empty", 32'(empty), 32'(model.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(model.size() >= AF_LVL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        model.delete();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_all();
        chk("validB", 32'(validB), 32'(m_valid));
        chk("outB", 32'(outB), 32'(m_out));
        check_status();
    endtask

    // One clock of stimulus: model predicts acceptance, scoreboard holds popped words until the DUT shows them.
    task automatic step(input logic wa, input logic [DATA_W-1:0] d, input logic rb);
        bit m_ra;
        bit m_wa;
        @(negedge clk);
        weA = wa; dataInA = d; weB = rb; clear = 1'b0;
        m_ra = rb && (model.size() != 0);
        m_wa = wa && ((model.size() < DEPTH) || m_ra);
        if (wa && model.size() == DEPTH && !m_ra) m_ovf = 1'b1;
        if (rb && model.size() == 0) m_unf = 1'b1;
        if (m_ra) exp_q.push_back(model.pop_front());
        if (m_wa) model.push_back(d);
        m_valid = m_ra;
        @(posedge clk); #1;
        weA = 1'b0; weB = 1'b0;
        if (m_ra) m_out = exp_q.pop_front();
        if (almost_full) af_seen = 1'b1;
        check_all();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; weA = 1'b1; weB = 1'b1; dataInA = 8'hEE;
        model_reset();
        @(posedge clk); #1;
        clear = 1'b0; weA = 1'b0; weB = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; weA = 1'b0; weB = 1'b0; dataInA = '0;
        model_reset();
        m_out = '0;
        af_seen = 1'b0;
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fill 0..15; almost_full must first appear exactly at count 12.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DATA_W'(i), 1'b0);
            chk("af_onset", 32'(af_seen), 32'(i + 1 >= AF_LVL));
        end

        // Write while full is dropped.
        step(1'b1, 8'hAA, 1'b0);

        // Drain in order, then read from empty.
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Simultaneous access on empty: write only, no fall-through.
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, '0, 1'b1);
        do_clear();

        // Pointer wrap with varied lengths.
        for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // Full with concurrent read/write streaming.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b1);
        do_clear();

        // Mid-stream asynchronous reset, observed before the next edge.
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h10 + i), 1'b0);
        step(1'b1, 8'h20, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        m_out = '0;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
